multdiv_sequencer: RTL and testbench

- Controls the 32-bit iterative multiply and divide units for the MIPS core.
- Accepts one mult/div operation from the execute stage and holds the operands stable.
- Issues a single-cycle start pulse to the selected unit, then waits for that unit's ready and captures its result and exception.
- Holds the pipeline stalled until it returns one tagged result to the write-back path.

---
 rtl/multdiv_sequencer_if.sv | 50 +++++
 rtl/multdiv_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_if.sv
// Bus bundle between the execute stage, the multdiv sequencer, the iterative
// multiply/divide units and the write-back path.
// slave  : the sequencer's view (accepts operations, drives units and results).
// master : the environment's view (execute stage, units, write-back).
`timescale 1ns/1ps
interface multdiv_sequencer_if #(
  parameter int unsigned TAG_W = 5
);
  // execute-stage request
  logic             op_valid;
  logic             op_is_div;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [TAG_W-1:0] op_dest;
  logic             op_ready;
  logic             stall;
  // unit control and operands
  logic             do_mult;
  logic             do_div;
  logic [31:0]      unit_a;
  logic [31:0]      unit_b;
  // unit responses
  logic             mult_ready;
  logic             mult_exception;
  logic [31:0]      mult_out;
  logic             div_ready;
  logic             div_exception;
  logic [31:0]      div_out;
  // write-back result
  logic             result_valid;
  logic [31:0]      result;
  logic [TAG_W-1:0] result_dest;
  logic             result_exception;

  modport slave (
    input  op_valid, op_is_div, op_a, op_b, op_dest,
    input  mult_ready, mult_exception, mult_out,
    input  div_ready, div_exception, div_out,
    output op_ready, stall, do_mult, do_div, unit_a, unit_b,
    output result_valid, result, result_dest, result_exception
  );

  modport master (
    output op_valid, op_is_div, op_a, op_b, op_dest,
    output mult_ready, mult_exception, mult_out,
    output div_ready, div_exception, div_out,
    input  op_ready, stall, do_mult, do_div, unit_a, unit_b,
    input  result_valid, result, result_dest, result_exception
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multiply/divide sequencer: accepts one operation, pulses the selected
// iterative unit, waits (with timeout) for its ready, then returns one tagged
// result while stalling the pipeline.
// Optional build macro MULTDIV_ZERO_SHORTCUT_EN: a divide by zero completes
// straight from IDLE with result 0 and the exception flag set, without
// starting the divider.
`timescale 1ns/1ps
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned TAG_W          = 5
) (
  input logic                clk,
  input logic                reset,
  multdiv_sequencer_if.slave bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [TAG_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_mult_q, do_mult_d;
  logic             do_div_q, do_div_d;
  logic [31:0]      unit_a_q, unit_a_d;
  logic [31:0]      unit_b_q, unit_b_d;
  logic             result_valid_q, result_valid_d;
  logic [31:0]      result_q, result_d;
  logic [TAG_W-1:0] result_dest_q, result_dest_d;
  logic             result_exc_q, result_exc_d;

  logic             accept;
  logic             sel_ready;
  logic             sel_exc;
  logic [31:0]      sel_out;

  // Acceptance and selected-unit response mux (the other unit is ignored).
  always_comb begin
    accept    = bus.op_valid && (state_q == IDLE) && !reset;
    sel_ready = is_div_q ? bus.div_ready     : bus.mult_ready;
    sel_exc   = is_div_q ? bus.div_exception : bus.mult_exception;
    sel_out   = is_div_q ? bus.div_out       : bus.mult_out;
  end

  // Next-state and registered-output computation for the sequencing FSM.
  always_comb begin
    state_d        = state_q;
    is_div_d       = is_div_q;
    dest_d         = dest_q;
    cnt_d          = cnt_q;
    unit_a_d       = unit_a_q;
    unit_b_d       = unit_b_q;
    do_mult_d      = 1'b0;
    do_div_d       = 1'b0;
    result_valid_d = 1'b0;
    result_d       = result_q;
    result_dest_d  = result_dest_q;
    result_exc_d   = result_exc_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          unit_a_d = bus.op_a;
          unit_b_d = bus.op_b;
          is_div_d = bus.op_is_div;
          dest_d   = bus.op_dest;
`ifdef MULTDIV_ZERO_SHORTCUT_EN
          if (bus.op_is_div && (bus.op_b == '0)) begin
            state_d        = DONE;
            result_valid_d = 1'b1;
            result_d       = '0;
            result_exc_d   = 1'b1;
            result_dest_d  = bus.op_dest;
          end else begin
            state_d   = LAUNCH;
            do_div_d  = bus.op_is_div;
            do_mult_d = ~bus.op_is_div;
          end
`else
          // Start pulse is registered here so it is high during LAUNCH.
          state_d   = LAUNCH;
          do_div_d  = bus.op_is_div;
          do_mult_d = ~bus.op_is_div;
`endif
        end
      end

      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      WAIT: begin
        // Ready is checked before the timeout so a last-cycle ready wins.
        if (sel_ready) begin
          state_d        = DONE;
          result_valid_d = 1'b1;
          result_d       = sel_out;
          result_exc_d   = sel_exc;
          result_dest_d  = dest_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = DONE;
          result_valid_d = 1'b1;
          result_d       = '0;
          result_exc_d   = 1'b1;
          result_dest_d  = dest_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      is_div_q       <= 1'b0;
      dest_q         <= '0;
      cnt_q          <= '0;
      do_mult_q      <= 1'b0;
      do_div_q       <= 1'b0;
      unit_a_q       <= '0;
      unit_b_q       <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_dest_q  <= '0;
      result_exc_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_div_q       <= is_div_d;
      dest_q         <= dest_d;
      cnt_q          <= cnt_d;
      do_mult_q      <= do_mult_d;
      do_div_q       <= do_div_d;
      unit_a_q       <= unit_a_d;
      unit_b_q       <= unit_b_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_dest_q  <= result_dest_d;
      result_exc_q   <= result_exc_d;
    end
  end

  assign bus.op_ready         = accept;
  assign bus.stall            = (state_q != IDLE);
  assign bus.do_mult          = do_mult_q;
  assign bus.do_div           = do_div_q;
  assign bus.unit_a           = unit_a_q;
  assign bus.unit_b           = unit_b_q;
  assign bus.result_valid     = result_valid_q;
  assign bus.result           = result_q;
  assign bus.result_dest      = result_dest_q;
  assign bus.result_exception = result_exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: a cycle-indexed driver plays the
// execute stage and both units, records every output per cycle, and each test
// compares the trace with timing/values derived from the operation rules.
`timescale 1ns/1ps
module tb_multdiv_sequencer;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  multdiv_sequencer_if #(.TAG_W(5)) bus ();
  multdiv_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // per-cycle trace of one operation; cycle 0 is the presentation cycle
  logic        tr_opr [0:63];
  logic        tr_stall [0:63];
  logic        tr_dm [0:63];
  logic        tr_dd [0:63];
  logic        tr_rv [0:63];
  logic        tr_exc [0:63];
  logic [31:0] tr_res [0:63];
  logic [31:0] tr_ua [0:63];
  logic [31:0] tr_ub [0:63];
  logic [4:0]  tr_dest [0:63];

  // Arithmetic the units perform: signed quotient / low product word.
  function automatic void ref_unit(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    if (is_div) begin
      if (b == 32'd0) begin r = 32'hFFFF_FFFF; e = 1'b1; end
      else begin r = $signed(a) / $signed(b); e = 1'b0; end
    end else begin
      r = $signed(a) * $signed(b);
      e = 1'b0;
    end
  endfunction

  function automatic bit shortcut(input bit is_div, input logic [31:0] b);
`ifdef MULTDIV_ZERO_SHORTCUT_EN
    return is_div && (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Unit ready lands at cycle 1+lat; only cycles 2..1+TIMEOUT are waiting cycles.
  function automatic int exp_rv(input bit is_div, input logic [31:0] b, input int lat);
    if (shortcut(is_div, b)) return 1;
    if (lat >= 1 && lat <= TIMEOUT) return 2 + lat;
    return 2 + TIMEOUT;
  endfunction

  function automatic void exp_result(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                     input int lat, output logic [31:0] r, output logic e);
    if (shortcut(is_div, b) || !(lat >= 1 && lat <= TIMEOUT)) begin r = 32'd0; e = 1'b1; end
    else ref_unit(is_div, a, b, r, e);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.mult_ready = 1'b0; bus.div_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Plays execute stage and both units for ncyc cycles. lat<0: unit never ready.
  // hold2: a second multiply (3*5, tag 7) is presented from cycle 1 onwards.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input int lat, input bit spur,
                        input bit hold2, input int rst_at, input int ncyc);
    logic [31:0] uo;
    logic        ue;
    int          rdy;
    ref_unit(is_div, a, b, uo, ue);
    rdy = (lat < 0) ? -1 : 1 + lat;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      reset = (c == rst_at);
      if (c == 0) begin
        bus.op_valid = 1'b1; bus.op_is_div = is_div; bus.op_a = a; bus.op_b = b; bus.op_dest = dest;
      end else if (hold2) begin
        bus.op_valid = 1'b1; bus.op_is_div = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.op_dest = 5'd7;
      end else begin
        bus.op_valid = 1'b0; bus.op_is_div = 1'($urandom); bus.op_a = $urandom;
        bus.op_b = $urandom; bus.op_dest = 5'($urandom);
      end
      bus.mult_ready = 1'b0; bus.div_ready = 1'b0;
      bus.mult_out = $urandom; bus.div_out = $urandom;
      bus.mult_exception = 1'($urandom); bus.div_exception = 1'($urandom);
      if (c == rdy) begin
        if (is_div) begin bus.div_ready = 1'b1; bus.div_out = uo; bus.div_exception = ue; end
        else begin bus.mult_ready = 1'b1; bus.mult_out = uo; bus.mult_exception = ue; end
      end
      if (spur && (c == 5 || c == rdy - 3)) begin
        if (is_div) begin bus.mult_ready = 1'b1; bus.mult_exception = 1'b1; end
        else begin bus.div_ready = 1'b1; bus.div_exception = 1'b1; end
      end
      @(negedge clk);
      tr_opr[c] = bus.op_ready;   tr_stall[c] = bus.stall;
      tr_dm[c]  = bus.do_mult;    tr_dd[c]    = bus.do_div;
      tr_rv[c]  = bus.result_valid; tr_res[c] = bus.result;
      tr_exc[c] = bus.result_exception; tr_dest[c] = bus.result_dest;
      tr_ua[c]  = bus.unit_a;     tr_ub[c]    = bus.unit_b;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.op_valid = 1'b1; bus.op_is_div = 1'b1; bus.op_a = 32'h1234_5678; bus.op_b = 32'h9; bus.op_dest = 5'd3;
    bus.mult_ready = 1'b1; bus.div_ready = 1'b1;
    bus.mult_out = 32'hDEAD_BEEF; bus.div_out = 32'hCAFE_F00D;
    bus.mult_exception = 1'b1; bus.div_exception = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if (bus.op_ready !== 1'b0) begin errs++; $display("FAIL rst_op_ready: got %b expected 0", bus.op_ready); end
    vecs++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL rst_stall: got %b expected 0", bus.stall); end
    vecs++; if (bus.do_mult !== 1'b0) begin errs++; $display("FAIL rst_do_mult: got %b expected 0", bus.do_mult); end
    vecs++; if (bus.do_div !== 1'b0) begin errs++; $display("FAIL rst_do_div: got %b expected 0", bus.do_div); end
    vecs++; if (bus.unit_a !== 32'd0) begin errs++; $display("FAIL rst_unit_a: got %h expected 0", bus.unit_a); end
    vecs++; if (bus.unit_b !== 32'd0) begin errs++; $display("FAIL rst_unit_b: got %h expected 0", bus.unit_b); end
    vecs++; if (bus.result_valid !== 1'b0) begin errs++; $display("FAIL rst_result_valid: got %b expected 0", bus.result_valid); end
    vecs++; if (bus.result !== 32'd0) begin errs++; $display("FAIL rst_result: got %h expected 0", bus.result); end
    vecs++; if (bus.result_dest !== 5'd0) begin errs++; $display("FAIL rst_result_dest: got %h expected 0", bus.result_dest); end
    vecs++; if (bus.result_exception !== 1'b0) begin errs++; $display("FAIL rst_result_exc: got %b expected 0", bus.result_exception); end
    @(posedge clk); #1;
    reset = 1'b0; bus.op_valid = 1'b0; bus.mult_ready = 1'b0; bus.div_ready = 1'b0;
    @(negedge clk);
    vecs++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL rst_exit_stall: got %b expected 0", bus.stall); end
    vecs++; if (bus.unit_a !== 32'd0) begin errs++; $display("FAIL rst_no_latch: got %h expected 0", bus.unit_a); end
  endtask

  task automatic test_divide();
    run_op(1'b1, 32'd100, 32'd7, 5'd13, 33, 1'b0, 1'b0, -1, 38);
    vecs++; if (tr_opr[0] !== 1'b1) begin errs++; $display("FAIL div_op_ready: got %b expected 1", tr_opr[0]); end
    for (int c = 0; c < 38; c++) begin
      vecs++; if (tr_dd[c] !== (c == 1)) begin errs++; $display("FAIL div_do_div[%0d]: got %b expected %b", c, tr_dd[c], c == 1); end
      vecs++; if (tr_dm[c] !== 1'b0) begin errs++; $display("FAIL div_do_mult[%0d]: got %b expected 0", c, tr_dm[c]); end
      vecs++; if (tr_rv[c] !== (c == 35)) begin errs++; $display("FAIL div_rv[%0d]: got %b expected %b", c, tr_rv[c], c == 35); end
      vecs++; if (tr_stall[c] !== (c >= 1 && c <= 35)) begin errs++; $display("FAIL div_stall[%0d]: got %b expected %b", c, tr_stall[c], c >= 1 && c <= 35); end
    end
    vecs++; if (tr_res[35] !== 32'd14) begin errs++; $display("FAIL div_result: got %h expected %h", tr_res[35], 32'd14); end
    vecs++; if (tr_exc[35] !== 1'b0) begin errs++; $display("FAIL div_exc: got %b expected 0", tr_exc[35]); end
    vecs++; if (tr_dest[35] !== 5'd13) begin errs++; $display("FAIL div_dest: got %0d expected 13", tr_dest[35]); end
    vecs++; if (tr_res[37] !== 32'd14) begin errs++; $display("FAIL div_result_hold: got %h expected %h", tr_res[37], 32'd14); end
  endtask

  task automatic test_multiply();
    run_op(1'b0, -32'sd6, 32'd7, 5'd9, 32, 1'b1, 1'b0, -1, 37);
    for (int c = 0; c < 37; c++) begin
      vecs++; if (tr_dd[c] !== 1'b0) begin errs++; $display("FAIL mul_do_div[%0d]: got %b expected 0", c, tr_dd[c]); end
      vecs++; if (tr_dm[c] !== (c == 1)) begin errs++; $display("FAIL mul_do_mult[%0d]: got %b expected %b", c, tr_dm[c], c == 1); end
      vecs++; if (tr_rv[c] !== (c == 34)) begin errs++; $display("FAIL mul_rv[%0d]: got %b expected %b", c, tr_rv[c], c == 34); end
    end
    vecs++; if (tr_res[34] !== 32'hFFFF_FFD6) begin errs++; $display("FAIL mul_result: got %h expected ffffffd6", tr_res[34]); end
    vecs++; if (tr_exc[34] !== 1'b0) begin errs++; $display("FAIL mul_exc: got %b expected 0", tr_exc[34]); end
    vecs++; if (tr_dest[34] !== 5'd9) begin errs++; $display("FAIL mul_dest: got %0d expected 9", tr_dest[34]); end
  endtask

  task automatic test_div_zero();
    int          erv;
    logic [31:0] er;
    logic        ee;
    erv = exp_rv(1'b1, 32'd0, 33);
    exp_result(1'b1, 32'd5, 32'd0, 33, er, ee);
    run_op(1'b1, 32'd5, 32'd0, 5'd17, 33, 1'b0, 1'b0, -1, erv + 3);
    for (int c = 0; c < erv + 3; c++) begin
      vecs++; if (tr_rv[c] !== (c == erv)) begin errs++; $display("FAIL dz_rv[%0d]: got %b expected %b", c, tr_rv[c], c == erv); end
      vecs++; if (tr_dd[c] !== (!shortcut(1'b1, 32'd0) && c == 1)) begin errs++; $display("FAIL dz_do_div[%0d]: got %b expected %b", c, tr_dd[c], !shortcut(1'b1, 32'd0) && c == 1); end
    end
    vecs++; if (tr_res[erv] !== er) begin errs++; $display("FAIL dz_result: got %h expected %h", tr_res[erv], er); end
    vecs++; if (tr_exc[erv] !== ee) begin errs++; $display("FAIL dz_exc: got %b expected %b", tr_exc[erv], ee); end
    vecs++; if (tr_dest[erv] !== 5'd17) begin errs++; $display("FAIL dz_dest: got %0d expected 17", tr_dest[erv]); end
  endtask

  task automatic test_busy_hold();
    run_op(1'b1, 32'd1000, 32'd9, 5'd4, 20, 1'b0, 1'b1, -1, 26);
    vecs++; if (tr_rv[22] !== 1'b1) begin errs++; $display("FAIL busy_rv: got %b expected 1", tr_rv[22]); end
    vecs++; if (tr_res[22] !== 32'd111) begin errs++; $display("FAIL busy_result: got %h expected %h", tr_res[22], 32'd111); end
    for (int c = 1; c < 26; c++) begin
      vecs++; if (tr_opr[c] !== (c == 23)) begin errs++; $display("FAIL busy_op_ready[%0d]: got %b expected %b", c, tr_opr[c], c == 23); end
    end
    for (int c = 1; c <= 23; c++) begin
      vecs++; if (tr_ua[c] !== 32'd1000) begin errs++; $display("FAIL busy_unit_a[%0d]: got %h expected %h", c, tr_ua[c], 32'd1000); end
      vecs++; if (tr_ub[c] !== 32'd9) begin errs++; $display("FAIL busy_unit_b[%0d]: got %h expected %h", c, tr_ub[c], 32'd9); end
    end
    vecs++; if (tr_ua[24] !== 32'd3) begin errs++; $display("FAIL busy_second_a: got %h expected 3", tr_ua[24]); end
    vecs++; if (tr_dm[24] !== 1'b1) begin errs++; $display("FAIL busy_second_do_mult: got %b expected 1", tr_dm[24]); end
    vecs++; if (tr_stall[23] !== 1'b0) begin errs++; $display("FAIL busy_idle_gap: got %b expected 0", tr_stall[23]); end
    do_reset();
  endtask

  task automatic test_timeout();
    run_op(1'b1, 32'd77, 32'd3, 5'd30, -1, 1'b0, 1'b0, -1, 45);
    for (int c = 0; c < 45; c++) begin
      vecs++; if (tr_rv[c] !== (c == 42)) begin errs++; $display("FAIL to_rv[%0d]: got %b expected %b", c, tr_rv[c], c == 42); end
    end
    vecs++; if (tr_res[42] !== 32'd0) begin errs++; $display("FAIL to_result: got %h expected 0", tr_res[42]); end
    vecs++; if (tr_exc[42] !== 1'b1) begin errs++; $display("FAIL to_exc: got %b expected 1", tr_exc[42]); end
    vecs++; if (tr_stall[43] !== 1'b0) begin errs++; $display("FAIL to_idle: got %b expected 0", tr_stall[43]); end
    // ready on the very last waiting cycle still wins over the timeout
    run_op(1'b0, 32'd12, 32'd12, 5'd1, TIMEOUT, 1'b0, 1'b0, -1, 45);
    vecs++; if (tr_rv[42] !== 1'b1) begin errs++; $display("FAIL to_edge_rv: got %b expected 1", tr_rv[42]); end
    vecs++; if (tr_res[42] !== 32'd144) begin errs++; $display("FAIL to_edge_result: got %h expected %h", tr_res[42], 32'd144); end
    vecs++; if (tr_exc[42] !== 1'b0) begin errs++; $display("FAIL to_edge_exc: got %b expected 0", tr_exc[42]); end
  endtask

  task automatic test_reset_mid();
    run_op(1'b0, 32'd9, 32'd11, 5'd4, 3, 1'b0, 1'b0, -1, 8);
    vecs++; if (tr_res[5] !== 32'd99) begin errs++; $display("FAIL rm_pre_result: got %h expected %h", tr_res[5], 32'd99); end
    run_op(1'b1, 32'd100, 32'd7, 5'd21, 33, 1'b0, 1'b0, 10, 40);
    vecs++; if (tr_stall[10] !== 1'b1) begin errs++; $display("FAIL rm_busy: got %b expected 1", tr_stall[10]); end
    vecs++; if (tr_ua[11] !== 32'd0) begin errs++; $display("FAIL rm_unit_a: got %h expected 0", tr_ua[11]); end
    vecs++; if (tr_ub[11] !== 32'd0) begin errs++; $display("FAIL rm_unit_b: got %h expected 0", tr_ub[11]); end
    vecs++; if (tr_res[11] !== 32'd0) begin errs++; $display("FAIL rm_result: got %h expected 0", tr_res[11]); end
    vecs++; if (tr_dest[11] !== 5'd0) begin errs++; $display("FAIL rm_dest: got %h expected 0", tr_dest[11]); end
    vecs++; if (tr_exc[11] !== 1'b0) begin errs++; $display("FAIL rm_exc: got %b expected 0", tr_exc[11]); end
    vecs++; if (tr_dd[11] !== 1'b0 || tr_dm[11] !== 1'b0) begin errs++; $display("FAIL rm_do: got %b%b expected 00", tr_dd[11], tr_dm[11]); end
    for (int c = 11; c < 40; c++) begin
      vecs++; if (tr_rv[c] !== 1'b0) begin errs++; $display("FAIL rm_rv[%0d]: got %b expected 0", c, tr_rv[c]); end
      vecs++; if (tr_stall[c] !== 1'b0) begin errs++; $display("FAIL rm_stall[%0d]: got %b expected 0", c, tr_stall[c]); end
    end
    run_op(1'b1, -32'sd50, 32'd5, 5'd2, 10, 1'b0, 1'b0, -1, 15);
    vecs++; if (tr_rv[12] !== 1'b1) begin errs++; $display("FAIL rm_after_rv: got %b expected 1", tr_rv[12]); end
    vecs++; if (tr_res[12] !== 32'hFFFF_FFF6) begin errs++; $display("FAIL rm_after_result: got %h expected fffffff6", tr_res[12]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      bit          isd;
      logic [31:0] av, bv, er;
      logic [4:0]  dv;
      logic        ee;
      int          lat, sel, erv;
      isd = 1'($urandom);
      av  = $urandom;
      if ($urandom_range(0, 1) == 0) av = 32'($urandom_range(0, 2000)) - 32'd1000;
      bv  = $urandom;
      if ($urandom_range(0, 1) == 0) bv = 32'($urandom_range(0, 60)) - 32'd30;
      if ($urandom_range(0, 5) == 0) bv = 32'd0;
      if (bv == 32'hFFFF_FFFF) bv = 32'd3;
      dv  = 5'($urandom);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: lat = -1;
        1: lat = 0;
        2: lat = TIMEOUT;
        3: lat = TIMEOUT + 1;
        default: lat = 1 + int'($urandom_range(0, 38));
      endcase
      erv = exp_rv(isd, bv, lat);
      exp_result(isd, av, bv, lat, er, ee);
      run_op(isd, av, bv, dv, lat, 1'b1, 1'b0, -1, erv + 2);
      vecs++; if (tr_opr[0] !== 1'b1) begin errs++; $display("FAIL b2b_op_ready[%0d]: got %b expected 1", i, tr_opr[0]); end
      for (int c = 0; c < erv + 2; c++) begin
        vecs++; if (tr_rv[c] !== (c == erv)) begin errs++; $display("FAIL b2b_rv[%0d][%0d]: got %b expected %b", i, c, tr_rv[c], c == erv); end
        vecs++; if (tr_dd[c] !== (isd && !shortcut(isd, bv) && c == 1)) begin errs++; $display("FAIL b2b_do_div[%0d][%0d]: got %b", i, c, tr_dd[c]); end
        vecs++; if (tr_dm[c] !== (!isd && c == 1)) begin errs++; $display("FAIL b2b_do_mult[%0d][%0d]: got %b", i, c, tr_dm[c]); end
      end
      vecs++; if (tr_res[erv] !== er) begin errs++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, tr_res[erv], er); end
      vecs++; if (tr_exc[erv] !== ee) begin errs++; $display("FAIL b2b_exc[%0d]: got %b expected %b", i, tr_exc[erv], ee); end
      vecs++; if (tr_dest[erv] !== dv) begin errs++; $display("FAIL b2b_dest[%0d]: got %0d expected %0d", i, tr_dest[erv], dv); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.op_is_div = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_dest = '0;
    bus.mult_ready = 1'b0; bus.mult_exception = 1'b0; bus.mult_out = '0;
    bus.div_ready = 1'b0; bus.div_exception = 1'b0; bus.div_out = '0;
    test_reset();
    do_reset();
    test_divide();
    test_multiply();
    test_div_zero();
    test_busy_hold();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
